// File: rtl/da_shift_accumulator_if.sv
// Valid/ready stream carrying a signed word of width W; the producer uses
// master, the consumer uses slave.
interface da_shift_accumulator_if #(
  parameter int W = 20
);
  logic                valid;
  logic                ready;
  logic signed [W-1:0] data;

  modport master (output valid, output data, input  ready);
  modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/da_shift_accumulator.sv
// Bit-serial shift-accumulate after the DA LUT: weights each activation plane
// by 2^idx, subtracts the sign plane, and hands off the dot product by valid/ready.
module da_shift_accumulator #(
  parameter int K            = 8,
  parameter int DATA_WIDTH_B = 16,
  parameter int DATA_WIDTH_A = 8,
  parameter int LUT_W        = DATA_WIDTH_B + $clog2(K) + 1,
  parameter int ACC_W        = LUT_W + DATA_WIDTH_A,
  parameter int IDX_W        = $clog2(DATA_WIDTH_A) + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  da_shift_accumulator_if.slave   in_if,
  da_shift_accumulator_if.master  out_if,
  output logic [IDX_W-1:0]        plane_idx_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH_A - 1);

  logic [1:0]              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] acc_out_q, acc_out_d;
  logic                    out_valid_q, out_valid_d;
  logic                    in_ready_q, in_ready_d;

  logic signed [LUT_W-1:0] lut;
  logic signed [ACC_W-1:0] ext, term, base, sum;
  logic                    accept, last;

  assign lut    = in_if.data;
  assign ext    = {{DATA_WIDTH_A{lut[LUT_W-1]}}, lut};
  assign term   = ext <<< idx_q;
  assign last   = (idx_q == LAST_IDX);
  // Plane 0 starts a fresh frame, so the old accumulator is ignored.
  assign base   = (idx_q == '0) ? '0 : acc_q;
  assign sum    = last ? (base - term) : (base + term);
  assign accept = in_if.valid && in_ready_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    acc_out_d   = acc_out_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    if (flush_i) begin
      state_d     = IDLE;
      idx_d       = '0;
      acc_d       = '0;
      out_valid_d = 1'b0;
      in_ready_d  = 1'b1;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          // IDLE and ACCUM share the update; DATA_WIDTH_A==1 finishes from IDLE.
          if (accept) begin
            if (last) begin
              acc_d       = sum;
              acc_out_d   = sum;
              out_valid_d = 1'b1;
              idx_d       = '0;
              in_ready_d  = 1'b0;
              state_d     = DONE;
            end else begin
              acc_d   = sum;
              idx_d   = idx_q + IDX_W'(1);
              state_d = ACCUM;
            end
          end
        end
        DONE: begin
          if (out_if.ready) begin
            out_valid_d = 1'b0;
            acc_d       = '0;
            in_ready_d  = 1'b1;
            state_d     = IDLE;
          end
        end
        default: begin
          state_d     = IDLE;
          idx_d       = '0;
          acc_d       = '0;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      acc_out_q   <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      acc_out_q   <= acc_out_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_if.ready  = in_ready_q;
  assign out_if.valid = out_valid_q;
  assign out_if.data  = acc_out_q;
  assign plane_idx_o  = idx_q;

endmodule

// File: tb/tb_da_shift_accumulator.sv
// Randomized bench for da_shift_accumulator (K=8, B=16, A=4) against an
// arithmetic dot-product model, plus the directed frames of interest.
module tb_da_shift_accumulator;
  localparam int K = 8, B = 16, A = 4;
  localparam int LW = B + $clog2(K) + 1;
  localparam int AW = LW + A;
  localparam int IW = $clog2(A) + 1;

  logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic [IW-1:0] plane_idx;
  int errs = 0, checks = 0;

  da_shift_accumulator_if #(.W(LW)) in_if ();
  da_shift_accumulator_if #(.W(AW)) out_if ();

  da_shift_accumulator #(.K(K), .DATA_WIDTH_B(B), .DATA_WIDTH_A(A)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_if(in_if), .out_if(out_if), .plane_idx_o(plane_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Reference: two's-complement weighting of bit planes, sign plane negated.
  function automatic longint model(input logic signed [LW-1:0] p [A]);
    longint s = 0;
    for (int i = 0; i < A; i++) begin
      if (i == A - 1) s -= longint'(p[i]) * (longint'(1) << i);
      else            s += longint'(p[i]) * (longint'(1) << i);
    end
    return s;
  endfunction

  task automatic send_frame(input logic signed [LW-1:0] p [A], input int g [A], input int bp);
    longint exp = model(p);
    for (int i = 0; i < A; i++) begin
      for (int j = 0; j < g[i]; j++) begin
        in_if.valid = 1'b0; in_if.data = LW'($urandom); step();
        chk("idx_gap", plane_idx, i);
      end
      in_if.valid = 1'b1; in_if.data = p[i];
      chk("idx", plane_idx, i);
      chk("in_ready", in_if.ready, 1);
      chk("ovld_early", out_if.valid, 0);
      step();
    end
    in_if.valid = 1'b0;
    chk("ovld", out_if.valid, 1);
    chk("acc_out", out_if.data, exp);
    chk("rdy_done", in_if.ready, 0);
    chk("idx_wrap", plane_idx, 0);
    for (int j = 0; j < bp; j++) begin
      in_if.valid = 1'b1; in_if.data = LW'($urandom); out_if.ready = 1'b0; step();
      chk("bp_vld", out_if.valid, 1);
      chk("bp_acc", out_if.data, exp);
      chk("bp_rdy", in_if.ready, 0);
      chk("bp_idx", plane_idx, 0);
    end
    out_if.ready = 1'b1; step();
    in_if.valid = 1'b0; out_if.ready = 1'b0;
    chk("hand_vld", out_if.valid, 0);
    chk("hand_rdy", in_if.ready, 1);
    chk("hand_acc", out_if.data, exp);
  endtask

  task automatic partial(input int n);
    for (int i = 0; i < n; i++) begin
      in_if.valid = 1'b1; in_if.data = LW'($urandom); step();
    end
  endtask

  logic signed [LW-1:0] p [A];
  int g [A];
  int g0 [A] = '{0, 0, 0, 0};

  initial begin
    in_if.valid = 1'b0; in_if.data = '0; out_if.ready = 1'b0;
    step(); step(); rst = 1'b0;
    chk("rst_rdy", in_if.ready, 1);
    chk("rst_vld", out_if.valid, 0);
    chk("rst_acc", out_if.data, 0);
    chk("rst_idx", plane_idx, 0);

    p = '{20'sd5, 20'sd3, 20'sd0, 20'sd1};       send_frame(p, g0, 0);
    p = '{-20'sd1, -20'sd1, -20'sd1, -20'sd1};   send_frame(p, g0, 0);
    chk("neg_one", model(p), 1);
    p = '{20'sd0, 20'sd0, 20'sd0, 20'sd1};       send_frame(p, g0, 0);
    p = '{20'h7FFFF, 20'h7FFFF, 20'h7FFFF, 20'h80000};
    send_frame(p, g0, 5);
    chk("max_model", model(p), 7864313);
    g = '{0, 2, 0, 1};
    p = '{20'sd2, 20'sd1, 20'sd1, 20'sd1};       send_frame(p, g, 0);

    // Mid-frame flush: plane presented with flush is dropped.
    partial(2);
    flush = 1'b1; in_if.valid = 1'b1; in_if.data = 20'sd99; step(); flush = 1'b0;
    chk("fl_idx", plane_idx, 0);
    chk("fl_vld", out_if.valid, 0);
    p = '{20'sd1, 20'sd0, 20'sd0, 20'sd0};       send_frame(p, g0, 0);

    partial(2);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rs_idx", plane_idx, 0);
    chk("rs_acc", out_if.data, 0);
    send_frame(p, g0, 1);

    // Flush while a result waits in DONE discards it.
    p = '{20'sd7, 20'sd1, 20'sd2, 20'sd0};
    for (int i = 0; i < A; i++) begin
      in_if.valid = 1'b1; in_if.data = p[i]; step();
    end
    in_if.valid = 1'b0;
    chk("dn_vld", out_if.valid, 1);
    flush = 1'b1; step(); flush = 1'b0;
    chk("dfl_vld", out_if.valid, 0);
    chk("dfl_rdy", in_if.ready, 1);
    chk("dfl_acc", out_if.data, model(p));

    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < A; i++) begin
        case ($urandom_range(0, 3))
          0: p[i] = 20'h7FFFF;
          1: p[i] = 20'h80000;
          default: p[i] = LW'($urandom);
        endcase
        g[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2) : 0;
      end
      send_frame(p, g, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/da_shift_accumulator.md
# da_shift_accumulator

Bit-serial shift-accumulate stage that sits directly downstream of the shared-LUT distributed-arithmetic block. It consumes one `LUT_out` partial sum per activation bit plane, LSB plane first. It weights each plane by 2^idx and subtracts the MSB (sign) plane, producing the two's-complement dot product of K activations with the K weights held in the LUT. The result is presented behind a valid/ready handshake to the next CNN stage (bias/activation).

## Interface
- `K`, 8, number of taps per LUT; sets the width of the LUT output.
- `DATA_WIDTH_B`, 16, weight width used by the LUT.
- `DATA_WIDTH_A`, 8, activation bit width, i.e. bit planes per dot product; must be ≥1.
- Derived: `LUT_W = DATA_WIDTH_B + $clog2(K) + 1`; `ACC_W = LUT_W + DATA_WIDTH_A`.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous abort of the current frame.
- `in_valid`  in  1  `lut_in` holds a valid bit-plane partial sum.
- `in_ready`  out  1  block can accept a plane this cycle.
- `lut_in`  in  LUT_W signed  partial sum from the LUT for the current plane.
- `out_valid`  out  1  `acc_out` holds a completed dot product.
- `out_ready`  in  1  downstream accepts `acc_out`.
- `acc_out`  out  ACC_W signed  completed dot product, registered.
- `plane_idx`  out  $clog2(DATA_WIDTH_A)+1  index of the next plane expected (debug/verification).

## Operation
- States: IDLE, ACCUM, DONE.
- **Accept** = `in_valid && in_ready`.
- `in_ready = 1` in IDLE and ACCUM; `in_ready = 0` in DONE.
- `ext = sign-extend(lut_in)` to ACC_W. Let `idx = plane_idx`.
- **Plane term:** `term = ext <<< idx`.
  - idx < DATA_WIDTH_A-1: term is added.
  - idx == DATA_WIDTH_A-1 (sign plane): term is negated.
- **Accumulator update on accept:**
  - idx == 0: `acc <= ±term`. The old accumulator value is ignored.
  - otherwise: `acc <= acc ± term`.
- ACC_W is sized so that no overflow is possible. Wrap-around is never required and no saturation logic is used.
- **IDLE:** accept → idx=1 and go to ACCUM. If DATA_WIDTH_A==1, go straight to DONE with `acc_out = -ext`.
- **ACCUM:**
  - Accept with idx < DATA_WIDTH_A-1 → idx+1.
  - Accept with idx == DATA_WIDTH_A-1 → `acc_out <=` final sum, `out_valid <= 1`, idx <= 0, go to DONE.
  - No accept → hold all state. Gaps in `in_valid` are legal.
- **DONE:**
  - `acc_out` and `out_valid` are held stable while `out_ready = 0`.
  - When `out_ready = 1`: `out_valid <= 0`, go to IDLE. The accumulator is cleared; `acc_out` keeps its last value.
  - `in_valid` is ignored while in DONE.
- **flush:** idx <= 0, acc <= 0, `out_valid <= 0`, go to IDLE. A pending result in DONE is discarded. Any plane presented in the same cycle is dropped.
- **Priority:** `rst` > `flush` > accept.

## Timing
- Reset values: state=IDLE, `in_ready=1`, `out_valid=0`, `acc_out=0`, `plane_idx=0`, internal acc=0.
- Latency: `out_valid` rises on the clock edge that accepts the final (sign) plane. It is visible the cycle after that accept.
- Throughput with no backpressure: one result per DATA_WIDTH_A+1 cycles. The extra cycle is DONE, with `out_ready=1`.
- The first plane of the next frame is accepted at the earliest in the cycle after the result handoff.
- `in_ready` is a registered function of state only, with no combinational path from `out_ready`.
- `rst` or `flush` asserted mid-frame takes effect at that edge. The partial sum never appears on `acc_out`.

## Test plan
Configuration for all tests: K=8, DATA_WIDTH_B=16, DATA_WIDTH_A=4, giving LUT_W=20 and ACC_W=24.
- Planes 5, 3, 0, 1 back-to-back → `out_valid` one cycle after the 4th accept, `acc_out = 5+6+0-8 = 3`; `plane_idx` reads 0,1,2,3,0.
- All four planes = -1 → `acc_out = -1-2-4+8 = 1`. Then planes 0,0,0,1 → `acc_out = -8`.
- Planes 0x7FFFF ×3, then 0x80000 → `acc_out = 7·524287 + 8·524288 = 7864313`, with no overflow.
- Backpressure: hold `out_ready=0` for 5 cycles after completion with `in_valid=1` → `out_valid` and `acc_out` stable, `in_ready=0`, no plane consumed. Release → next frame starts from a fresh accumulator.
- Gaps: `in_valid` toggling 1,0,0,1,1,0,1 with planes 2,1,1,1 → `acc_out = 2+2+4-8 = 0`.
- Abort: `flush` (and separately `rst`) after 2 planes, then planes 1,0,0,0 → `acc_out = 1`, with no trace of the aborted frame. `flush` during DONE → `out_valid` drops next cycle.
